// File: rtl/delay_timer_arbiter_pkg.sv
// Shared constants and state encoding for the delay timer arbiter family.
// Default values match a 50 kHz system clock with 1 ms ticks.
package delay_timer_arbiter_pkg;

    localparam int DIV_DEFAULT     = 50;
    localparam int DELAY_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/delay_timer_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above the pointer,
// wrapping modulo N (N need not be a power of two).
module rr_pick
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] win_o,
    output logic          valid_o
);

    logic [PW:0] idx;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        win_o   = '0;
        valid_o = |req_i;
        idx     = '0;
        for (int o = N - 1; o >= 0; o--) begin
            idx = {1'b0, ptr_i} + (PW + 1)'(o);
            if (idx >= (PW + 1)'(N)) begin
                idx = idx - (PW + 1)'(N);
            end
            if (req_i[idx[PW-1:0]]) begin
                win_o = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// One shared ms-resolution delay timer, granted round-robin to N_REQ requesters.
// Counts D*DIV clock cycles for the winner, then pulses done for one cycle.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DIV     = DIV_DEFAULT,
    parameter int DELAY_W = DELAY_W_DEFAULT
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DELAY_W-1:0]   delay_ms,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic                       tick_out
);

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    state_t               state_q, state_d;
    logic [PW-1:0]        win_q, win_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [DELAY_W-1:0]   ms_q, ms_d;
    logic                 tick_q, tick_d;

    logic [PW-1:0]        pick_win;
    logic                 pick_valid;
    logic [DELAY_W-1:0]   pick_delay;
    logic [PW-1:0]        ptr_next;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    assign pick_delay = delay_ms[int'(pick_win)*DELAY_W +: DELAY_W];
    assign ptr_next   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            presc_q <= '0;
            ms_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_win;
                    ms_d    = pick_delay;
                    presc_d = '0;
                    state_d = (pick_delay == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident ms wrap: the owner no longer wants the result.
                if (!req[win_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_next;
                    presc_d = '0;
                end else if (presc_q == PRE_W'(DIV - 1)) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (ms_q != '0) begin
                        ms_d = ms_q - DELAY_W'(1);
                    end
                    if (ms_q <= DELAY_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant    = (state_q == ST_RUN)  ? (N_REQ'(1) << win_q) : '0;
    assign done     = (state_q == ST_DONE) ? (N_REQ'(1) << win_q) : '0;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign tick_out = tick_q;

endmodule
